// File: rtl/jpeg_qtable_bank.sv
// -----------------------------------------------------------------------------
// jpeg_qtable_bank
//
// Quantisation-table bank for the JPEG encoder. It holds 2**TBL_W runtime
// tables of 64 entries each. A start request rebuilds one table from the
// standard base table (luminance for even table indices, chrominance for odd
// ones), scaled by an unsigned Q8 factor (256 = 1.0), through a three-stage
// pipeline:
//   ROM read -> multiply/round/clamp -> RAM write.
// After reset every table is rebuilt at unit scale before the bank goes idle.
//
// Optional feature macro: QTABLE_HOST_WR_EN
//   defined   : wr_* ports write the RAM while the bank is idle.
//   undefined : wr_* ports are present but ignored.
//
// Ports
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   start_i    start a scale run (honoured only while busy_o = 0)
//   scale_i    Q8 scale factor, sampled with start_i
//   tbl_sel_i  table to rebuild, sampled with start_i
//   busy_o     init or scale run in progress
//   done_o     one-cycle pulse when a start_i-initiated run finishes
//   rd_i       read request
//   rd_tbl_i   read table
//   rd_addr_i  read address (raster index 0..63)
//   data_o     registered read data
//   valid_o    data_o holds the result of the read issued last cycle
//   wr_i       host write strobe
//   wr_tbl_i   host write table
//   wr_addr_i  host write address
//   wr_data_i  host write data
// -----------------------------------------------------------------------------
module jpeg_qtable_bank #(
  parameter int DATA_W  = 11,
  parameter int TBL_W   = 1,
  parameter int SCALE_W = 16,
  parameter int Q_MAX   = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [SCALE_W-1:0] scale_i,
  input  logic [TBL_W-1:0]   tbl_sel_i,
  output logic               busy_o,
  output logic               done_o,
  input  logic               rd_i,
  input  logic [TBL_W-1:0]   rd_tbl_i,
  input  logic [5:0]         rd_addr_i,
  output logic [DATA_W-1:0]  data_o,
  output logic               valid_o,
  input  logic               wr_i,
  input  logic [TBL_W-1:0]   wr_tbl_i,
  input  logic [5:0]         wr_addr_i,
  input  logic [DATA_W-1:0]  wr_data_i
);

  localparam int NUM_TBL = 2 ** TBL_W;
  localparam int P_W     = DATA_W + SCALE_W;

  // Standard JPEG base tables, raster order.
  localparam logic [7:0] LUMA_ROM [64] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  localparam logic [7:0] CHROMA_ROM [64] = '{
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
  };

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SCALE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Base entry lookup; odd tables use the chrominance base.
  function automatic logic [DATA_W-1:0] base_rom(input logic sel, input logic [5:0] addr);
    logic [7:0] b;
    if (sel) begin
      b = CHROMA_ROM[addr];
    end else begin
      b = LUMA_ROM[addr];
    end
    return {{(DATA_W-8){1'b0}}, b};
  endfunction

  // Q8 multiply with round-half-up, then clamp into [1, Q_MAX].
  function automatic logic [DATA_W-1:0] scale_entry(input logic [DATA_W-1:0] base,
                                                    input logic [SCALE_W-1:0] scale);
    logic [P_W-1:0] p;
    logic [P_W-1:0] r;
    logic [DATA_W-1:0] q;
    p = P_W'(base) * P_W'(scale);
    r = (p + P_W'(9'd128)) >> 8;
    if (r == P_W'(1'b0)) begin
      q = DATA_W'(1'b1);
    end else if (r > P_W'(Q_MAX)) begin
      q = DATA_W'(Q_MAX);
    end else begin
      q = r[DATA_W-1:0];
    end
    return q;
  endfunction

  state_t             state_r, state_s;
  logic [5:0]         cnt_r, cnt_s;
  logic [TBL_W-1:0]   tbl_r, tbl_s;
  logic               dcnt_r, dcnt_s;
  logic               init_r, init_s;
  logic [SCALE_W-1:0] scale_r, scale_s;
  logic               issue_s;
  logic               fin_s;
  logic               busy_r;
  logic               done_pend_r;
  logic               done_r;

  logic               s1_vld_r;
  logic [TBL_W-1:0]   s1_tbl_r;
  logic [5:0]         s1_addr_r;
  logic [DATA_W-1:0]  s1_base_r;
  logic [SCALE_W-1:0] s1_scale_r;
  logic               s2_vld_r;
  logic [TBL_W-1:0]   s2_tbl_r;
  logic [5:0]         s2_addr_r;
  logic [DATA_W-1:0]  s2_q_r;

  logic [DATA_W-1:0]  ram_r [NUM_TBL][64];
  logic [DATA_W-1:0]  data_r;
  logic               valid_r;
  logic               host_we_s;

`ifdef QTABLE_HOST_WR_EN
  // Host writes only land while the bank reports idle.
  assign host_we_s = wr_i & ~busy_r;
`else
  logic unused_wr_s;
  assign host_we_s   = 1'b0;
  assign unused_wr_s = wr_i;
`endif

  // FSM state and run-context registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_INIT;
      cnt_r   <= 6'd0;
      tbl_r   <= '0;
      dcnt_r  <= 1'b0;
      init_r  <= 1'b1;
      scale_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      tbl_r   <= tbl_s;
      dcnt_r  <= dcnt_s;
      init_r  <= init_s;
      scale_r <= scale_s;
    end
  end

  // Next-state logic: INIT walks every table, SCALE walks one, DRAIN flushes
  // the two pipeline stages before moving on.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    tbl_s   = tbl_r;
    dcnt_s  = dcnt_r;
    init_s  = init_r;
    scale_s = scale_r;
    issue_s = 1'b0;
    fin_s   = 1'b0;
    case (state_r)
      ST_INIT, ST_SCALE: begin
        issue_s = 1'b1;
        if (cnt_r == 6'd63) begin
          state_s = ST_DRAIN;
          cnt_s   = 6'd0;
          dcnt_s  = 1'b0;
        end else begin
          cnt_s = cnt_r + 6'd1;
        end
      end
      ST_DRAIN: begin
        if (dcnt_r) begin
          if (init_r && (tbl_r != TBL_W'(NUM_TBL - 1))) begin
            state_s = ST_INIT;
            tbl_s   = tbl_r + TBL_W'(1'b1);
            cnt_s   = 6'd0;
          end else begin
            state_s = ST_IDLE;
            fin_s   = ~init_r;
            init_s  = 1'b0;
          end
        end else begin
          dcnt_s = 1'b1;
        end
      end
      ST_IDLE: begin
        // busy_r lags the state by a cycle, so check both.
        if (start_i && !busy_r) begin
          state_s = ST_SCALE;
          scale_s = scale_i;
          tbl_s   = tbl_sel_i;
          cnt_s   = 6'd0;
          init_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
  end

  // busy/done outputs; done is delayed one cycle so it coincides with busy
  // falling, which itself trails the FSM by a cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_r      <= 1'b1;
      done_pend_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      busy_r      <= (state_r != ST_IDLE);
      done_pend_r <= fin_s;
      done_r      <= done_pend_r;
    end
  end

  // Pipeline stage 1: ROM read and run context.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld_r   <= 1'b0;
      s1_tbl_r   <= '0;
      s1_addr_r  <= 6'd0;
      s1_base_r  <= '0;
      s1_scale_r <= '0;
    end else begin
      s1_vld_r   <= issue_s;
      s1_tbl_r   <= tbl_r;
      s1_addr_r  <= cnt_r;
      s1_base_r  <= base_rom(tbl_r[0], cnt_r);
      s1_scale_r <= (state_r == ST_INIT) ? SCALE_W'(9'd256) : scale_r;
    end
  end

  // Pipeline stage 2: scaled, rounded and clamped entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_vld_r  <= 1'b0;
      s2_tbl_r  <= '0;
      s2_addr_r <= 6'd0;
      s2_q_r    <= '0;
    end else begin
      s2_vld_r  <= s1_vld_r;
      s2_tbl_r  <= s1_tbl_r;
      s2_addr_r <= s1_addr_r;
      s2_q_r    <= scale_entry(s1_base_r, s1_scale_r);
    end
  end

  // Table RAM write port; the internal pipeline wins over the host.
  always_ff @(posedge clk_i) begin
    if (s2_vld_r) begin
      ram_r[s2_tbl_r][s2_addr_r] <= s2_q_r;
    end else if (host_we_s) begin
      ram_r[wr_tbl_i][wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port; returns the pre-write value on a same-edge collision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= rd_i;
      if (rd_i) begin
        data_r <= ram_r[rd_tbl_i][rd_addr_i];
      end
    end
  end

  assign busy_o  = busy_r;
  assign done_o  = done_r;
  assign data_o  = data_r;
  assign valid_o = valid_r;

endmodule

// File: tb/tb_jpeg_qtable_bank.sv
// -----------------------------------------------------------------------------
// tb_jpeg_qtable_bank
//
// Self-checking bench for jpeg_qtable_bank at default parameters. A vector
// table drives scale runs and read-backs against hand-computed results;
// hand-written sequences cover init length, busy-time start/host write,
// back-to-back runs, read/write collision timing and mid-run reset.
// -----------------------------------------------------------------------------
module tb_jpeg_qtable_bank;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [15:0] scale_i;
  logic [0:0]  tbl_sel_i;
  logic        busy_o;
  logic        done_o;
  logic        rd_i;
  logic [0:0]  rd_tbl_i;
  logic [5:0]  rd_addr_i;
  logic [10:0] data_o;
  logic        valid_o;
  logic        wr_i;
  logic [0:0]  wr_tbl_i;
  logic [5:0]  wr_addr_i;
  logic [10:0] wr_data_i;

  int n_tests = 0;
  int n_fail  = 0;

  jpeg_qtable_bank dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .scale_i   (scale_i),
    .tbl_sel_i (tbl_sel_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .rd_i      (rd_i),
    .rd_tbl_i  (rd_tbl_i),
    .rd_addr_i (rd_addr_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .wr_i      (wr_i),
    .wr_tbl_i  (wr_tbl_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        run;
    logic [15:0] scale;
    logic [0:0]  run_tbl;
    logic [0:0]  rd_tbl;
    logic [5:0]  addr;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_read(input string name, input logic [0:0] t, input logic [5:0] a,
                         input logic [10:0] exp);
    rd_i      = 1'b1;
    rd_tbl_i  = t;
    rd_addr_i = a;
    tick();
    rd_i = 1'b0;
    check({name, " valid"}, 32'(valid_o), 32'd1);
    check(name, 32'(data_o), 32'(exp));
  endtask

  // Starts a run at edge k and checks busy/done timing through edge k+68.
  task automatic run_scale(input logic [15:0] s, input logic [0:0] t);
    start_i   = 1'b1;
    scale_i   = s;
    tbl_sel_i = t;
    tick();
    start_i = 1'b0;
    for (int i = 1; i <= 66; i++) begin
      tick();
      if (i == 1) check("busy rises k+1", 32'(busy_o), 32'd1);
      if (i == 66) begin
        check("busy k+66", 32'(busy_o), 32'd1);
        check("done k+66", 32'(done_o), 32'd0);
      end
    end
    tick();
    check("done k+67", 32'(done_o), 32'd1);
    check("busy falls k+67", 32'(busy_o), 32'd0);
    tick();
    check("done pulse width", 32'(done_o), 32'd0);
  endtask

  // Releases reset and counts the busy cycles; bounded at 300 edges.
  task automatic release_and_count(input string name);
    int hi;
    int seen_low;
    hi = 0;
    seen_low = 0;
    rst_i = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (!busy_o) begin
        seen_low = 1;
        break;
      end
      hi++;
    end
    check({name, " busy ended"}, 32'(seen_low), 32'd1);
    check({name, " busy cycles"}, 32'(hi), 32'd132);
  endtask

  initial begin
    int done_cnt;
    int done_at0;
    int done_at1;
    logic [10:0] exp_d;
    logic [10:0] exp_host;

    vecs[0]  = '{1'b1, 16'd512, 1'b0, 1'b0, 6'd22, 11'd138};
    vecs[1]  = '{1'b0, 16'd0,   1'b0, 1'b0, 6'd61, 11'd200};
    vecs[2]  = '{1'b0, 16'd0,   1'b0, 1'b1, 6'd0,  11'd17};
    vecs[3]  = '{1'b0, 16'd0,   1'b0, 1'b0, 6'd0,  11'd32};
    vecs[4]  = '{1'b1, 16'd660, 1'b0, 1'b0, 6'd61, 11'd255};
    vecs[5]  = '{1'b0, 16'd0,   1'b0, 1'b0, 6'd22, 11'd178};
    vecs[6]  = '{1'b1, 16'd640, 1'b0, 1'b0, 6'd61, 11'd250};
    vecs[7]  = '{1'b1, 16'd1,   1'b0, 1'b0, 6'd0,  11'd1};
    vecs[8]  = '{1'b0, 16'd0,   1'b0, 1'b0, 6'd61, 11'd1};
    vecs[9]  = '{1'b1, 16'd768, 1'b1, 1'b1, 6'd0,  11'd51};
    vecs[10] = '{1'b0, 16'd0,   1'b0, 1'b1, 6'd63, 11'd255};
    vecs[11] = '{1'b1, 16'd256, 1'b1, 1'b1, 6'd63, 11'd99};
    vecs[12] = '{1'b1, 16'd256, 1'b0, 1'b0, 6'd22, 11'd69};

    rst_i = 1'b1; start_i = 1'b0; scale_i = 16'd0; tbl_sel_i = 1'b0;
    rd_i = 1'b0; rd_tbl_i = 1'b0; rd_addr_i = 6'd0;
    wr_i = 1'b0; wr_tbl_i = 1'b0; wr_addr_i = 6'd0; wr_data_i = 11'd0;

    // Reset values.
    repeat (3) tick();
    check("reset busy", 32'(busy_o), 32'd1);
    check("reset done", 32'(done_o), 32'd0);
    check("reset valid", 32'(valid_o), 32'd0);
    check("reset data", 32'(data_o), 32'd0);

    release_and_count("init");
    do_read("init t0 a0", 1'b0, 6'd0, 11'd16);
    do_read("init t1 a0", 1'b1, 6'd0, 11'd17);
    do_read("init t0 a22", 1'b0, 6'd22, 11'd69);
    tick();
    check("valid idle", 32'(valid_o), 32'd0);
    check("data hold", 32'(data_o), 32'd69);

    // Vector table: optional scale run then a read-back.
    for (int v = 0; v < 13; v++) begin
      if (vecs[v].run) run_scale(vecs[v].scale, vecs[v].run_tbl);
      do_read($sformatf("vec%0d", v), vecs[v].rd_tbl, vecs[v].addr, vecs[v].exp);
    end

    // Start and host write during busy, then a back-to-back run.
    done_cnt = 0; done_at0 = 0; done_at1 = 0;
    scale_i = 16'd512; tbl_sel_i = 1'b0; start_i = 1'b1;
    tick();
    for (int i = 1; i <= 140; i++) begin
      start_i   = (i == 6) || (i == 68);
      scale_i   = (i == 68) ? 16'd256 : 16'd512;
      wr_i      = (i == 6);
      wr_tbl_i  = 1'b1;
      wr_addr_i = 6'd5;
      wr_data_i = 11'd300;
      tick();
      if (done_o) begin
        done_cnt++;
        if (done_cnt == 1) done_at0 = i;
        if (done_cnt == 2) done_at1 = i;
      end
    end
    start_i = 1'b0; wr_i = 1'b0;
    check("done count", 32'(done_cnt), 32'd2);
    check("first done edge", 32'(done_at0), 32'd67);
    check("back-to-back done edge", 32'(done_at1), 32'd135);
    do_read("busy write dropped", 1'b1, 6'd5, 11'd99);
    do_read("b2b restored t0", 1'b0, 6'd22, 11'd69);

    // Host write while idle.
`ifdef QTABLE_HOST_WR_EN
    exp_host = 11'd300;
`else
    exp_host = 11'd99;
`endif
    wr_i = 1'b1; wr_tbl_i = 1'b1; wr_addr_i = 6'd5; wr_data_i = 11'd300;
    tick();
    wr_i = 1'b0;
    do_read("idle host write", 1'b1, 6'd5, exp_host);

    // Continuous reads of table 0 addr 10 across its write at edge k+13.
    rd_i = 1'b1; rd_tbl_i = 1'b0; rd_addr_i = 6'd10;
    scale_i = 16'd512; tbl_sel_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      exp_d = (j >= 14) ? 11'd28 : 11'd14;
      check($sformatf("collide valid k+%0d", j), 32'(valid_o), 32'd1);
      check($sformatf("collide data k+%0d", j), 32'(data_o), 32'(exp_d));
    end
    rd_i = 1'b0;
    for (int j = 21; j <= 80 && !done_o; j++) tick();
    check("collide run done", 32'(done_o), 32'd1);

    // Mid-run reset during a scale-512 run with reads in flight.
    tick();
    rd_i = 1'b1; rd_tbl_i = 1'b0; rd_addr_i = 6'd22;
    scale_i = 16'd512; tbl_sel_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (30) tick();
    check("pre-reset data", 32'(data_o), 32'd138);
    rst_i = 1'b1;
    #1;
    check("mid reset busy", 32'(busy_o), 32'd1);
    check("mid reset done", 32'(done_o), 32'd0);
    check("mid reset valid", 32'(valid_o), 32'd0);
    check("mid reset data", 32'(data_o), 32'd0);
    rd_i = 1'b0;
    tick();
    release_and_count("reinit");
    do_read("reinit t0 a22", 1'b0, 6'd22, 11'd69);
    do_read("reinit t0 a10", 1'b0, 6'd10, 11'd14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jpeg_qtable_bank.md
# jpeg_qtable_bank

Quantisation-table bank for the JPEG encoder datapath, next to the quantiser. It holds 2**TBL_W runtime tables of 64 entries each. On request, it rebuilds any table from the standard base table, scaled by a Q8 quality factor, using an internal pipelined FSM. After reset it self-initialises every table to unit scale. It adds an optional host write port and a registered read port with a valid flag.

## Interface
- DATA_W, 11: entry width; stored values are non-negative, so the MSB is always 0.
- TBL_W, 1: table-select width; the bank holds 2**TBL_W tables.
- SCALE_W, 16: width of the unsigned Q8 scale factor (256 = 1.0).
- Q_MAX, 255: upper clamp for scaled entries.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, asynchronous, active-high.
- start_i, in, 1: start a scale run; honoured only when busy_o = 0.
- scale_i, in, SCALE_W: scale factor, sampled with start_i.
- tbl_sel_i, in, TBL_W: table to rebuild, sampled with start_i.
- busy_o, out, 1: init or scale run in progress.
- done_o, out, 1: one-cycle pulse at the end of a start_i-initiated run.
- rd_i, in, 1: read request.
- rd_tbl_i, in, TBL_W: read table.
- rd_addr_i, in, 6: read address (zig-zag-free raster index 0..63).
- data_o, out, DATA_W: read data, registered.
- valid_o, out, 1: data_o valid for the read issued on the previous cycle.
- wr_i, in, 1: host write strobe.
- wr_tbl_i, in, TBL_W: host write table.
- wr_addr_i, in, 6: host write address.
- wr_data_i, in, DATA_W: host write data.

## Operation
- Base ROM: table index t uses base table (t mod 2).
  - Base 0 is the standard luminance table (raster order, entry 0 = 16, entry 22 = 69, entry 61 = 100).
  - Base 1 is the standard chrominance table (entry 0 = 17, entry 63 = 99).
- Working RAM: 2**TBL_W x 64 x DATA_W.
- Scale arithmetic:
  - p = base * scale, full DATA_W + SCALE_W bits.
  - r = (p + 128) >> 8.
  - q = 1 if r = 0; q = Q_MAX if r > Q_MAX; otherwise q = r.
- FSM states are INIT, IDLE, SCALE and DRAIN.
  - INIT: entered on reset. Rebuilds tables 0..2**TBL_W-1 in order at scale 256, then goes to IDLE. No done_o pulse.
  - IDLE → SCALE: on start_i. Latches scale_i and tbl_sel_i.
  - SCALE: address counter 0..63, one address per cycle. When the counter reaches 63, go to DRAIN.
  - DRAIN: 2 cycles to flush the pipeline, then IDLE with done_o pulsed.
- Pipeline stages: ROM read at edge n, multiply/round/clamp registered at edge n+1, RAM write at edge n+2.
- start_i while busy_o = 1 is ignored: no queueing, no extra done_o.
- Reads:
  - Always served, including during busy.
  - Return the RAM content as of the read edge.
  - A read and a write to the same entry on the same edge return the old value.
- Host writes:
  - Accepted when busy_o = 0.
  - Dropped silently when busy_o = 1.
  - An internal write has priority.

## Timing
- Reset values: busy_o = 1, done_o = 0, valid_o = 0, data_o = 0. FSM in INIT with counter 0.
- Init length: busy_o stays high for exactly 66 * 2**TBL_W cycles after the first rising edge with rst_i low (132 cycles at the defaults).
- Scale run, start_i sampled at edge k:
  - busy_o = 1 from edge k+1.
  - Writes to addresses 0..63 occur at edges k+3..k+66.
  - At edge k+67, busy_o falls and done_o rises for one cycle.
- Read latency: rd_i at edge k gives data_o and valid_o at edge k+1. valid_o = 0 on cycles without rd_i. data_o holds its last value when rd_i = 0.
- start_i is accepted at the edge where done_o is high, giving back-to-back runs.
- rst_i asserted mid-run: outputs return to their reset values immediately, the run is abandoned, and INIT re-runs over all tables.

## Configuration
- QTABLE_HOST_WR_EN defined: the host write port is functional as described.
- QTABLE_HOST_WR_EN undefined:
  - The wr_* ports remain present but are ignored.
  - The RAM is modified only by INIT and SCALE runs.

## Test plan
- Reset release, wait 132 cycles: busy_o falls at cycle 132. Read table 0 addr 0 → 16; table 1 addr 0 → 17; table 0 addr 22 → 69.
- start_i with scale 512, table 0: done_o pulses at k+67. Then addr 22 → 138, addr 61 → 200, table 1 unchanged (addr 0 = 17).
- Clamp cases:
  - Scale 660, table 0: addr 61 → 255 (clamped from 258).
  - Scale 640: addr 61 → 250.
  - Scale 1: every entry → 1.
- start_i again during busy, and a host write during busy: no second done_o, and the write is dropped. Same host write while idle (table 1 addr 5 = 300) reads back 300 (only with QTABLE_HOST_WR_EN).
- rst_i pulsed at k+30 during a scale-512 run: busy_o stays 1 for 132 cycles after release, then table 0 addr 22 → 69 (unit scale restored).
- Read of table 0 addr 10 issued every cycle during a run: valid_o is 1 each following cycle, data_o changes from the old value to the scaled value the cycle after the edge-k+13 write.
